result_buffer: RTL and testbench

- Output stage directly downstream of the dot-product datapath (two multipliers feeding one adder).
- Captures each 17-bit result together with the 10-bit address produced by the address generator for that result.
- Buffers results in a first-word-fall-through FIFO and hands them to the memory/host side over a valid/ready handshake.
- Absorbs back-pressure so the arithmetic pipeline never stalls, and flags any result lost to a full buffer.

---
 rtl/result_buffer.sv | 91 +++++++++
 tb/tb_result_buffer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/result_buffer.sv
// result_buffer: first-word-fall-through FIFO that sits after the dot-product
// adder. Each entry holds {addr, data}. The buffer never back-pressures the
// arithmetic pipeline: a result that arrives while full is dropped and the
// sticky overflow flag is raised.
module result_buffer #(
  parameter int DATA_WIDTH = 17,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [ADDR_WIDTH-1:0]   out_addr,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push, pop;
  logic [EW-1:0] head;

  // Status and handshake are purely combinational from the registered count.
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = en & ~full;
  assign out_valid = en & ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;
  assign overflow  = overflow_q;

  // Head entry falls through with no read latency; zeroed while empty so
  // stale storage never leaks onto the bus.
  assign head     = mem_q[rd_ptr_q];
  assign out_data = empty ? '0 : head[DATA_WIDTH-1:0];
  assign out_addr = empty ? '0 : head[EW-1:DATA_WIDTH];

  // Next-state for pointers, occupancy and the sticky drop flag. Pointers are
  // exactly log2(DEPTH) bits wide so increment wraps DEPTH-1 -> 0 for free.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (en & in_valid & full);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards all entries logically at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is write-only on push and deliberately has no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_addr, in_data};
  end

endmodule

// File: tb/tb_result_buffer.sv
// Scoreboard bench for result_buffer: the stimulus process keeps a queue-based
// model (expected entries, occupancy, sticky drop flag); a separate monitor on
// the falling edge compares status and pops/compares head entries.
module tb_result_buffer;
  localparam int DW = 17;
  localparam int AW = 10;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_addr;
  logic          in_ready, out_valid, full, empty, overflow;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic [4:0]    count;

  result_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_addr(in_addr), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_addr(out_addr), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  logic [AW+DW-1:0] exp_q[$];
  int  mcount = 0;
  bit  movf   = 1'b0;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then apply the FIFO rules to the model at the edge.
  task automatic step(input bit e, input bit v, input logic [DW-1:0] d,
                      input logic [AW-1:0] a, input bit r);
    bit fm, pu, po;
    en = e; in_valid = v; in_data = d; in_addr = a; out_ready = r;
    @(posedge clk);
    fm = (mcount == DEPTH);
    if (e && v && fm) movf = 1'b1;
    pu = e && v && !fm;
    po = e && r && (mcount > 0);
    if (pu) exp_q.push_back({a, d});
    mcount = mcount + int'(pu) - int'(po);
    #1;
  endtask

  // Monitor: status against the model every cycle, head entry against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      chk("count", 32'(count), 32'(mcount));
      chk("full", 32'(full), 32'(mcount == DEPTH));
      chk("empty", 32'(empty), 32'(mcount == 0));
      chk("overflow", 32'(overflow), 32'(movf));
      chk("in_ready", 32'(in_ready), 32'(en && mcount < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(en && mcount > 0));
      if (exp_q.size() > 0) begin
        if (out_valid) begin
          chk("out_data", 32'(out_data), 32'(exp_q[0][DW-1:0]));
          chk("out_addr", 32'(out_addr), 32'(exp_q[0][AW+DW-1:DW]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("out_data_empty", 32'(out_data), 32'd0);
        chk("out_addr_empty", 32'(out_addr), 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b0; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_addr = '0;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    // First push of an all-ones result: MSB must survive.
    step(1, 0, '0, '0, 0);
    step(1, 1, 17'h1FFFF, 10'h005, 0);
    chk("first_out_data", 32'(out_data), 32'h1FFFF);
    chk("first_out_addr", 32'(out_addr), 32'h005);
    chk("first_count", 32'(count), 32'd1);
    step(1, 0, '0, '0, 0);
    step(1, 0, '0, '0, 1);

    // Fill to full, then a dropped 17th result.
    for (int k = 0; k < DEPTH; k++) step(1, 1, DW'(k * 3), AW'(k), 0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    step(1, 1, 17'h00ABC, 10'h3FF, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    for (int k = 0; k < DEPTH + 1; k++) step(1, 0, '0, '0, 1);
    chk("drain_empty", 32'(empty), 32'd1);

    // Steady push+pop at occupancy 5, long enough to wrap pointers.
    for (int k = 0; k < 5; k++) step(1, 1, DW'($urandom), AW'($urandom), 0);
    for (int k = 0; k < 20; k++) step(1, 1, DW'($urandom), AW'($urandom), 1);
    chk("steady_count", 32'(count), 32'd5);

    // Enable low: everything frozen, inputs ignored.
    for (int k = 0; k < 3; k++) step(0, 1, DW'($urandom), AW'($urandom), 1);
    chk("en_low_count", 32'(count), 32'd5);
    chk("en_low_out_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 8; k++) step(1, 0, '0, '0, 1);

    // Reset with 9 entries and overflow set.
    for (int k = 0; k < 9; k++) step(1, 1, DW'($urandom), AW'($urandom), 0);
    chk("pre_rst_count", 32'(count), 32'd9);
    en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    exp_q.delete(); mcount = 0; movf = 1'b0;
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    step(1, 1, 17'h10203, 10'h2A5, 0);
    chk("post_rst_data", 32'(out_data), 32'h10203);
    chk("post_rst_addr", 32'(out_addr), 32'h2A5);
    step(1, 0, '0, '0, 1);

    // Pop on empty must not underflow.
    for (int k = 0; k < 3; k++) step(1, 0, '0, '0, 1);
    chk("empty_pop_count", 32'(count), 32'd0);
    chk("empty_pop_empty", 32'(empty), 32'd1);

    // Randomized traffic, biased toward enabled operation.
    for (int k = 0; k < 1500; k++)
      step($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, DW'($urandom),
           AW'($urandom), $urandom_range(0, 2) != 0);
    for (int k = 0; k < DEPTH + 2; k++) step(1, 0, '0, '0, 1);
    chk("final_count", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
